// File: rtl/ad9958_spi_master_if.sv
// Request and serial-pin bundle between the DDS sequencing core and the AD9958 serial engine.
// Latency: none, signal grouping only.
// Backpressure: the core holds off new requests while busy is high.
interface ad9958_spi_master_if;
  // request side, driven by the sequencing core
  logic        trigger;
  logic        four_bit;
  logic [5:0]  bits_to_send;
  logic [63:0] data_input;
  // status and AD9958 serial pins, driven by the engine
  logic        busy;
  logic        sclk;
  logic        cs_n;
  logic [3:0]  sdio;

  modport master (
    input  trigger, four_bit, bits_to_send, data_input,
    output busy, sclk, cs_n, sdio
  );

  modport slave (
    output trigger, four_bit, bits_to_send, data_input,
    input  busy, sclk, cs_n, sdio
  );
endinterface

// File: rtl/ad9958_spi_master.sv
// Shifts one AD9958 instruction/register word out MSB first in 1-bit or 4-bit serial mode.
// Latency: busy, cs_n and the first symbol register at the edge sampling trigger; busy lasts 2*CLK_DIV*N cycles.
// Backpressure: triggers while busy (or with zero length) are dropped; cs_n lingers CS_HOLD cycles for follow-on words.
module ad9958_spi_master #(
  parameter int CLK_DIV = 2,
  parameter int CS_HOLD = 16
) (
  input logic                 clock,
  input logic                 reset_n,
  ad9958_spi_master_if.master bus
);

  localparam int DIV_W  = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV + 1);
  localparam int HOLD_W = (CS_HOLD < 2) ? 1 : $clog2(CS_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOW    = 2'd1,
    S_HIGH   = 2'd2,
    S_LINGER = 2'd3
  } state_t;

  state_t              state;
  logic [63:0]         sr;
  logic                mode;
  logic [6:0]          sym_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                busy_q;
  logic                sclk_q;
  logic                cs_n_q;
  logic [3:0]          sdio_q;

  logic                accept;
  logic [63:0]         load_sr;
  logic [6:0]          load_n;
  logic [63:0]         shifted_sr;

  // Symbol presented on the pins for the word currently at the top of the shift register.
  function automatic logic [3:0] sym_of(input logic [63:0] v, input logic m);
    return m ? v[63:60] : {3'b000, v[63]};
  endfunction

  // New requests are only taken between transfers; a zero-length word is never a transfer.
  assign accept  = bus.trigger && (bus.bits_to_send != 6'd0) &&
                   ((state == S_IDLE) || (state == S_LINGER));
  // Left-justify the word so its first bit sits at bit 63; vacated low bits pad a short final nibble.
  assign load_sr = bus.data_input << (7'd64 - {1'b0, bus.bits_to_send});
  assign load_n  = bus.four_bit ? (({1'b0, bus.bits_to_send} + 7'd3) >> 2)
                                : {1'b0, bus.bits_to_send};
  assign shifted_sr = mode ? (sr << 4) : (sr << 1);

  // Transfer sequencer: accept, SCLK low/high phases, then hold cs_n low waiting for a follow-on word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      sr       <= 64'd0;
      mode     <= 1'b0;
      sym_cnt  <= 7'd0;
      div_cnt  <= '0;
      hold_cnt <= '0;
      busy_q   <= 1'b0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      sdio_q   <= 4'd0;
    end else if (accept) begin
      state    <= S_LOW;
      sr       <= load_sr;
      mode     <= bus.four_bit;
      sym_cnt  <= load_n;
      div_cnt  <= '0;
      hold_cnt <= '0;
      busy_q   <= 1'b1;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b0;
      sdio_q   <= sym_of(load_sr, bus.four_bit);
    end else begin
      case (state)
        S_LOW: begin
          if (int'(div_cnt) + 1 >= CLK_DIV) begin
            div_cnt <= '0;
            sclk_q  <= 1'b1;
            state   <= S_HIGH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (int'(div_cnt) + 1 >= CLK_DIV) begin
            div_cnt <= '0;
            sclk_q  <= 1'b0;
            if (sym_cnt > 7'd1) begin
              // data only moves on the falling edge, centring it on the next rising edge
              sym_cnt <= sym_cnt - 7'd1;
              sr      <= shifted_sr;
              sdio_q  <= sym_of(shifted_sr, mode);
              state   <= S_LOW;
            end else begin
              sym_cnt  <= 7'd0;
              sdio_q   <= 4'd0;
              busy_q   <= 1'b0;
              hold_cnt <= '0;
              state    <= S_LINGER;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_LINGER: begin
          if (int'(hold_cnt) + 1 >= CS_HOLD) begin
            cs_n_q <= 1'b1;
            state  <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.sclk = sclk_q;
  assign bus.cs_n = cs_n_q;
  assign bus.sdio = sdio_q;

endmodule

// File: tb/tb_ad9958_spi_master.sv
// Bench for the AD9958 serial engine: directed scenarios plus randomized words against a bit-level model.
// Latency: samples on the falling clock edge, half a cycle after each register update.
// Backpressure: each transfer is awaited to completion under a cycle bound before the next is issued.
module tb_ad9958_spi_master;
  localparam int CLK_DIV = 2;
  localparam int CS_HOLD = 16;

  logic clock;
  logic reset_n;
  ad9958_spi_master_if bus();

  ad9958_spi_master #(.CLK_DIV(CLK_DIV), .CS_HOLD(CS_HOLD)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] cap_q[$];
  logic [3:0] exp_q[$];
  int         cap_busy;
  int         exp_busy;
  bit         cap_cs_ok;
  bit         cap_timeout;
  logic       cap_first_busy;
  logic       cap_first_cs;
  logic [3:0] cap_first_sdio;

  // Reference: the symbol stream is the word read MSB first, one bit or four bits per SCLK,
  // with positions below bit 0 reading as zero.
  task automatic model(input bit fb, input int nb, input logic [63:0] d);
    logic [3:0] s;
    int idx;
    exp_q.delete();
    if (fb) begin
      for (int k = 0; 4 * k < nb; k++) begin
        for (int j = 0; j < 4; j++) begin
          idx = nb - 1 - 4 * k - j;
          s[3 - j] = (idx >= 0) ? d[idx] : 1'b0;
        end
        exp_q.push_back(s);
      end
    end else begin
      for (int k = 0; k < nb; k++) exp_q.push_back({3'b000, d[nb - 1 - k]});
    end
    exp_busy = 2 * CLK_DIV * exp_q.size();
  endtask

  // Issue one request and record the symbol seen at every SCLK rising edge until busy drops.
  task automatic xfer(input bit fb, input int nb, input logic [63:0] d);
    logic prev;
    int guard;
    cap_q.delete();
    cap_busy = 0; cap_cs_ok = 1; cap_timeout = 0;
    @(negedge clock);
    bus.four_bit = fb; bus.bits_to_send = nb[5:0]; bus.data_input = d; bus.trigger = 1'b1;
    @(negedge clock);
    bus.trigger = 1'b0;
    cap_first_busy = bus.busy; cap_first_cs = bus.cs_n; cap_first_sdio = bus.sdio;
    prev = 1'b0; guard = 0;
    while (bus.busy === 1'b1 && guard < 20000) begin
      if (bus.cs_n !== 1'b0) cap_cs_ok = 0;
      if (bus.sclk === 1'b1 && prev === 1'b0) cap_q.push_back(bus.sdio);
      prev = bus.sclk; cap_busy++; guard++;
      @(negedge clock);
    end
    if (guard >= 20000) cap_timeout = 1;
  endtask

  task automatic test_reset();
    bus.trigger = 1'b0; bus.four_bit = 1'b0; bus.bits_to_send = 6'd0; bus.data_input = 64'd0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.sclk !== 1'b0) begin n_errors++; $display("FAIL reset_sclk: got %b want 0", bus.sclk); end
    n_checks++; if (bus.cs_n !== 1'b1) begin n_errors++; $display("FAIL reset_cs_n: got %b want 1", bus.cs_n); end
    n_checks++; if (bus.sdio !== 4'd0) begin n_errors++; $display("FAIL reset_sdio: got %h want 0", bus.sdio); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_one_bit();
    logic [7:0] want;
    int bad;
    want = 8'b0011_0101;
    xfer(0, 8, 64'h35);
    n_checks++; if (cap_timeout) begin n_errors++; $display("FAIL one_bit_timeout: busy got %b want 0", bus.busy); end
    n_checks++; if (cap_first_busy !== 1'b1 || cap_first_cs !== 1'b0 || cap_first_sdio !== 4'd0) begin
      n_errors++; $display("FAIL one_bit_accept: busy/cs_n/sdio got %b/%b/%h want 1/0/0", cap_first_busy, cap_first_cs, cap_first_sdio); end
    bad = (cap_q.size() != 8) ? 1 : 0;
    for (int i = 0; i < cap_q.size() && i < 8; i++) if (cap_q[i] !== {3'b000, want[7 - i]}) bad = 1;
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL one_bit_symbols: got %0d symbols first %h want 8 symbols 0,0,1,1,0,1,0,1", cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 4'hx); end
    n_checks++; if (cap_busy != 32) begin n_errors++; $display("FAIL one_bit_busy_len: got %0d want 32", cap_busy); end
    n_checks++; if (!cap_cs_ok) begin n_errors++; $display("FAIL one_bit_cs_low: got cs_n high during transfer want 0"); end
  endtask

  task automatic test_four_bit();
    int bad;
    xfer(1, 32, 64'h12345678);
    bad = (cap_q.size() != 8) ? 1 : 0;
    for (int i = 0; i < cap_q.size() && i < 8; i++) if (cap_q[i] !== 4'(i + 1)) bad = 1;
    n_checks++; if (cap_timeout || bad != 0) begin n_errors++; $display("FAIL four_bit_symbols: got %0d symbols first %h want 1..8", cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 4'hx); end
    n_checks++; if (cap_busy != 32) begin n_errors++; $display("FAIL four_bit_busy_len: got %0d want 32", cap_busy); end
    n_checks++; if (cap_first_sdio !== 4'h1) begin n_errors++; $display("FAIL four_bit_first: got %h want 1", cap_first_sdio); end
  endtask

  task automatic test_short_nibble();
    int bad;
    xfer(1, 10, 64'h3FF);
    bad = (cap_q.size() != 3) ? 1 : 0;
    if (bad == 0 && (cap_q[0] !== 4'hF || cap_q[1] !== 4'hF || cap_q[2] !== 4'hC)) bad = 1;
    n_checks++; if (cap_timeout || bad != 0) begin n_errors++; $display("FAIL short_nibble: got %0d symbols last %h want F,F,C", cap_q.size(), (cap_q.size() > 0) ? cap_q[cap_q.size() - 1] : 4'hx); end
    n_checks++; if (cap_busy != 2 * CLK_DIV * 3) begin n_errors++; $display("FAIL short_nibble_busy_len: got %0d want %0d", cap_busy, 2 * CLK_DIV * 3); end
  endtask

  task automatic test_back_to_back();
    logic gap_cs;
    int cnt;
    int bad;
    // let any previous frame close first so this one starts from IDLE
    cnt = 0;
    while (bus.cs_n !== 1'b1 && cnt < 200) begin cnt++; @(negedge clock); end
    xfer(0, 8, 64'h04);
    gap_cs = bus.cs_n;
    xfer(0, 32, 64'hDEADBEEF);
    model(0, 32, 64'hDEADBEEF);
    n_checks++; if (gap_cs !== 1'b0 || cap_first_cs !== 1'b0) begin n_errors++; $display("FAIL frame_gap_cs: got %b/%b want 0/0", gap_cs, cap_first_cs); end
    bad = (cap_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) if (cap_q[i] !== exp_q[i]) bad = 1;
    n_checks++; if (cap_timeout || bad != 0) begin n_errors++; $display("FAIL frame_cftw_symbols: got %0d symbols want %0d", cap_q.size(), exp_q.size()); end
    cnt = 0;
    while (bus.cs_n === 1'b0 && cnt < 200) begin cnt++; @(negedge clock); end
    n_checks++; if (cnt != CS_HOLD) begin n_errors++; $display("FAIL frame_cs_release: got %0d cycles want %0d", cnt, CS_HOLD); end
  endtask

  task automatic test_ignored();
    int bad;
    int cnt;
    logic [63:0] d;
    d = {$urandom, $urandom};
    model(0, 32, d);
    fork
      xfer(0, 32, d);
      begin
        repeat (12) @(negedge clock);
        bus.trigger = 1'b1; bus.bits_to_send = 6'd8; bus.data_input = 64'hFF; bus.four_bit = 1'b1;
        @(negedge clock);
        bus.trigger = 1'b0;
      end
    join
    bad = (cap_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) if (cap_q[i] !== exp_q[i]) bad = 1;
    n_checks++; if (cap_timeout || bad != 0) begin n_errors++; $display("FAIL ignore_busy_symbols: got %0d symbols want %0d", cap_q.size(), exp_q.size()); end
    n_checks++; if (cap_busy != exp_busy) begin n_errors++; $display("FAIL ignore_busy_len: got %0d want %0d", cap_busy, exp_busy); end
    cnt = 0;
    while (bus.cs_n !== 1'b1 && cnt < 200) begin cnt++; @(negedge clock); end
    bus.trigger = 1'b1; bus.bits_to_send = 6'd0; bus.data_input = 64'hFFFF;
    @(negedge clock);
    bus.trigger = 1'b0;
    bad = 0;
    for (int i = 0; i < 4 * CLK_DIV; i++) begin
      if (bus.busy !== 1'b0 || bus.cs_n !== 1'b1 || bus.sclk !== 1'b0) bad = 1;
      @(negedge clock);
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL ignore_zero_len: got activity busy/cs_n/sclk %b/%b/%b want 0/1/0", bus.busy, bus.cs_n, bus.sclk); end
  endtask

  task automatic test_reset_mid();
    int rises;
    int guard;
    logic prev;
    int bad;
    @(negedge clock);
    bus.four_bit = 1'b0; bus.bits_to_send = 6'd32; bus.data_input = {$urandom, $urandom}; bus.trigger = 1'b1;
    @(negedge clock);
    bus.trigger = 1'b0;
    rises = 0; guard = 0; prev = 1'b0;
    while (rises < 5 && guard < 1000) begin
      @(negedge clock);
      if (bus.sclk === 1'b1 && prev === 1'b0) rises++;
      prev = bus.sclk; guard++;
    end
    n_checks++; if (rises != 5) begin n_errors++; $display("FAIL reset_mid_reach: got %0d sclk edges want 5", rises); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.sclk !== 1'b0 || bus.cs_n !== 1'b1 || bus.busy !== 1'b0 || bus.sdio !== 4'd0) begin
      n_errors++; $display("FAIL reset_mid_outputs: sclk/cs_n/busy/sdio got %b/%b/%b/%h want 0/1/0/0", bus.sclk, bus.cs_n, bus.busy, bus.sdio); end
    @(negedge clock);
    reset_n = 1'b1;
    xfer(0, 8, 64'hA5);
    model(0, 8, 64'hA5);
    bad = (cap_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) if (cap_q[i] !== exp_q[i]) bad = 1;
    n_checks++; if (cap_timeout || bad != 0 || cap_busy != 32) begin n_errors++; $display("FAIL reset_mid_after: got %0d symbols busy %0d want 8 symbols busy 32", cap_q.size(), cap_busy); end
  endtask

  task automatic test_random();
    bit fb;
    int nb;
    int bad;
    logic [63:0] d;
    for (int t = 0; t < 25; t++) begin
      fb = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 63);
      d  = {$urandom, $urandom};
      model(fb, nb, d);
      xfer(fb, nb, d);
      bad = (cap_q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) if (cap_q[i] !== exp_q[i]) bad = 1;
      n_checks++; if (cap_timeout || bad != 0) begin n_errors++; $display("FAIL rand_symbols[%0d]: fb=%0d nb=%0d got %0d symbols want %0d", t, fb, nb, cap_q.size(), exp_q.size()); end
      n_checks++; if (cap_busy != exp_busy) begin n_errors++; $display("FAIL rand_busy_len[%0d]: got %0d want %0d", t, cap_busy, exp_busy); end
      n_checks++; if (cap_first_busy !== 1'b1 || cap_first_cs !== 1'b0 || cap_first_sdio !== exp_q[0] || !cap_cs_ok) begin
        n_errors++; $display("FAIL rand_accept[%0d]: busy/cs_n/sdio got %b/%b/%h want 1/0/%h", t, cap_first_busy, cap_first_cs, cap_first_sdio, exp_q[0]); end
      repeat ($urandom_range(0, 25)) @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_one_bit();
    test_four_bit();
    test_short_nibble();
    test_back_to_back();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
